// File: rtl/bringup_pkg.sv
// State encoding shared by the bring-up sequencer and its display path.
package bringup_pkg;

  localparam int STATE_W = 4;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 4'd0,
    ST_STARTUP    = 4'd1,
    ST_INIT_START = 4'd2,
    ST_INIT_WAIT  = 4'd3,
    ST_RD_START   = 4'd4,
    ST_RD_WAIT    = 4'd5
  } state_t;

endpackage

// File: rtl/tick_gen.sv
// Delay prescaler: one-cycle tick every TICK_DIV enabled cycles; clr restarts the count.
// Tick is combinational from the prescaler register, high while it sits at TICK_DIV-1.
module tick_gen #(
  parameter int TICK_DIV = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] presc_q, presc_d;

  assign tick = en && (presc_q == LAST);

  always_comb begin
    presc_d = presc_q;
    if (clr) begin
      presc_d = '0;
    end else if (en) begin
      presc_d = (presc_q == LAST) ? '0 : presc_q + PW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

endmodule

// File: rtl/i2c_bringup_seq.sv
// I2C bring-up sequencer: PLL-lock wait, per-device init with timeout/retry, then register reads.
// All outputs are registered; start pulses coincide with the INIT_START/RD_START cycle.
module i2c_bringup_seq #(
  parameter int N_DEV         = 2,
  parameter int DEV_W         = 1,
  parameter int TICK_DIV      = 50,
  parameter int STARTUP_DELAY = 500000,
  parameter int INIT_TIMEOUT  = 1000000,
  parameter int RD_TIMEOUT    = 100,
  parameter int MAX_RETRIES   = 2,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pll_locked,
  output logic [N_DEV-1:0] init_start,
  input  logic [N_DEV-1:0] init_done,
  input  logic             reinit,
  input  logic             rd_req,
  input  logic [DEV_W-1:0] rd_dev,
  output logic [N_DEV-1:0] rd_start,
  input  logic [N_DEV-1:0] rd_done,
  output logic             rd_ack,
  output logic             rd_err,
  output logic [N_DEV-1:0] dev_ok,
  output logic             init_fail,
  output logic             busy,
  output logic [3:0]       state_out
);

  import bringup_pkg::*;

  localparam int RET_W = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;
  localparam int PAD_N = 1 << DEV_W;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] delay_q, delay_d;
  logic [DEV_W-1:0] dev_q, dev_d;
  logic [RET_W-1:0] retry_q, retry_d;
  logic             first_q, first_d;
  logic [N_DEV-1:0] dev_ok_q, dev_ok_d;
  logic [N_DEV-1:0] init_start_q, init_start_d;
  logic [N_DEV-1:0] rd_start_q, rd_start_d;
  logic             init_fail_q, init_fail_d;
  logic             rd_ack_q, rd_ack_d;
  logic             rd_err_q, rd_err_d;
  logic             busy_q, busy_d;

  logic             tick, tick_en, state_chg, advance;
  logic [N_DEV-1:0] sel_cur, sel_nxt;
  logic [PAD_N-1:0] ok_pad;
  logic             init_hit, rd_hit, last_dev;

  assign sel_cur   = N_DEV'(1) << dev_q;
  assign init_hit  = |(init_done & sel_cur);
  assign rd_hit    = |(rd_done & sel_cur);
  assign last_dev  = (dev_q == DEV_W'(N_DEV - 1));
  assign tick_en   = (state_q != ST_STARTUP) || pll_locked;
  assign state_chg = (state_d != state_q);

  // Out-of-range read targets land on zero padding and are rejected.
  always_comb begin
    ok_pad = '0;
    ok_pad[N_DEV-1:0] = dev_ok_q;
  end

  tick_gen #(
    .TICK_DIV(TICK_DIV)
  ) u_tick (
    .clk (clk),
    .rst (reset),
    .clr (state_chg),
    .en  (tick_en),
    .tick(tick)
  );

  always_comb begin
    state_d     = state_q;
    dev_d       = dev_q;
    retry_d     = retry_q;
    dev_ok_d    = dev_ok_q;
    init_fail_d = init_fail_q;
    rd_ack_d    = 1'b0;
    rd_err_d    = 1'b0;
    advance     = 1'b0;

    case (state_q)
      ST_STARTUP: begin
        if (delay_q == CNT_W'(STARTUP_DELAY)) begin
          state_d = ST_INIT_START;
          dev_d   = '0;
          retry_d = '0;
        end
      end
      ST_INIT_START: state_d = ST_INIT_WAIT;
      ST_INIT_WAIT: begin
        // first_q masks a done flag left over from the previous attempt.
        if (!first_q && init_hit) begin
          dev_ok_d = dev_ok_q | sel_cur;
          retry_d  = '0;
          advance  = 1'b1;
        end else if (delay_q == CNT_W'(INIT_TIMEOUT)) begin
          if (retry_q < RET_W'(MAX_RETRIES)) begin
            retry_d = retry_q + RET_W'(1);
            state_d = ST_INIT_START;
          end else begin
            init_fail_d = 1'b1;
            retry_d     = '0;
            advance     = 1'b1;
          end
        end
      end
      ST_IDLE: begin
        if (reinit) begin
          dev_ok_d    = '0;
          init_fail_d = 1'b0;
          dev_d       = '0;
          retry_d     = '0;
          state_d     = ST_INIT_START;
        end else if (rd_req) begin
          if (ok_pad[rd_dev]) begin
            dev_d   = rd_dev;
            state_d = ST_RD_START;
          end else begin
            rd_err_d = 1'b1;
          end
        end
      end
      ST_RD_START: state_d = ST_RD_WAIT;
      ST_RD_WAIT: begin
        if (!first_q && rd_hit) begin
          rd_ack_d = 1'b1;
          state_d  = ST_IDLE;
        end else if (delay_q == CNT_W'(RD_TIMEOUT)) begin
          rd_err_d = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_STARTUP;
    endcase

    if (advance) begin
      if (last_dev) begin
        state_d = ST_IDLE;
      end else begin
        dev_d   = dev_q + DEV_W'(1);
        state_d = ST_INIT_START;
      end
    end

    // Losing lock anywhere past STARTUP drops everything and restarts the power-up wait.
    if (state_q != ST_STARTUP && !pll_locked) begin
      state_d  = ST_STARTUP;
      dev_ok_d = '0;
      dev_d    = '0;
      retry_d  = '0;
      rd_ack_d = 1'b0;
      rd_err_d = 1'b0;
    end

    sel_nxt      = N_DEV'(1) << dev_d;
    init_start_d = (state_d == ST_INIT_START) ? sel_nxt : '0;
    rd_start_d   = (state_d == ST_RD_START) ? sel_nxt : '0;
    busy_d       = (state_d != ST_IDLE);
    first_d      = state_chg;

    delay_d = delay_q;
    if (state_chg) begin
      delay_d = '0;
    end else if (tick && (delay_q != '1)) begin
      delay_d = delay_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_STARTUP;
      delay_q      <= '0;
      dev_q        <= '0;
      retry_q      <= '0;
      first_q      <= 1'b0;
      dev_ok_q     <= '0;
      init_start_q <= '0;
      rd_start_q   <= '0;
      init_fail_q  <= 1'b0;
      rd_ack_q     <= 1'b0;
      rd_err_q     <= 1'b0;
      busy_q       <= 1'b1;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      dev_q        <= dev_d;
      retry_q      <= retry_d;
      first_q      <= first_d;
      dev_ok_q     <= dev_ok_d;
      init_start_q <= init_start_d;
      rd_start_q   <= rd_start_d;
      init_fail_q  <= init_fail_d;
      rd_ack_q     <= rd_ack_d;
      rd_err_q     <= rd_err_d;
      busy_q       <= busy_d;
    end
  end

  assign init_start = init_start_q;
  assign rd_start   = rd_start_q;
  assign rd_ack     = rd_ack_q;
  assign rd_err     = rd_err_q;
  assign dev_ok     = dev_ok_q;
  assign init_fail  = init_fail_q;
  assign busy       = busy_q;
  assign state_out  = state_q;

endmodule

// File: tb/tb_i2c_bringup_seq.sv
// Directed bench for i2c_bringup_seq with behavioural init/read engines answering after a set latency.
module tb_i2c_bringup_seq;

  logic       clk = 1'b0;
  logic       reset, pll_locked, reinit, rd_req;
  logic [0:0] rd_dev;
  logic [1:0] init_start, init_done, rd_start, rd_done, dev_ok;
  logic       rd_ack, rd_err, init_fail, busy;
  logic [3:0] state_out;

  int cyc = 0;
  int passed = 0;
  int total = 0;
  int init_lat [2];
  int rd_lat   [2];
  int init_cnt [2];
  int rd_cnt   [2];
  int t0, c0, a, b;

  i2c_bringup_seq #(
    .N_DEV(2), .DEV_W(1), .TICK_DIV(4), .STARTUP_DELAY(10),
    .INIT_TIMEOUT(20), .RD_TIMEOUT(5), .MAX_RETRIES(2), .CNT_W(32)
  ) dut (
    .clk(clk), .reset(reset), .pll_locked(pll_locked),
    .init_start(init_start), .init_done(init_done), .reinit(reinit),
    .rd_req(rd_req), .rd_dev(rd_dev), .rd_start(rd_start), .rd_done(rd_done),
    .rd_ack(rd_ack), .rd_err(rd_err), .dev_ok(dev_ok), .init_fail(init_fail),
    .busy(busy), .state_out(state_out)
  );

  initial forever #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Engines: a start pulse clears done; done rises lat cycles later and holds (lat 0 = never).
  initial begin
    init_done = '0;
    rd_done   = '0;
    init_cnt  = '{0, 0};
    rd_cnt    = '{0, 0};
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        if (init_start[i] === 1'b1) begin
          init_done[i] = 1'b0;
          init_cnt[i]  = init_lat[i];
        end else if (init_cnt[i] > 0) begin
          init_cnt[i]--;
          if (init_cnt[i] == 0) init_done[i] = 1'b1;
        end
        if (rd_start[i] === 1'b1) begin
          rd_done[i] = 1'b0;
          rd_cnt[i]  = rd_lat[i];
        end else if (rd_cnt[i] > 0) begin
          rd_cnt[i]--;
          if (rd_cnt[i] == 0) rd_done[i] = 1'b1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic wait_init(input int idx, output int at);
    at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (init_start[idx] === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic wait_rd_start(input int idx, output int at);
    at = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd_start[idx] === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic wait_rd_end(output int at);
    at = -1;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (rd_ack === 1'b1 || rd_err === 1'b1) begin at = cyc; break; end
    end
  endtask

  task automatic wait_state(input logic [3:0] st, output int at);
    at = -1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      if (state_out === st) begin at = cyc; break; end
    end
  endtask

  initial begin
    reset = 1'b1; pll_locked = 1'b1; reinit = 1'b0; rd_req = 1'b0; rd_dev = '0;
    init_lat = '{3, 3};
    rd_lat   = '{2, 2};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_state", state_out, 1);
    check("rst_busy", busy, 1);
    check("rst_dev_ok", dev_ok, 0);
    check("rst_pulses", {init_start, rd_start, rd_ack, rd_err, init_fail}, 0);

    // Boot: STARTUP lasts 10*4+1 cycles, each device answers 3 cycles after its start
    reset = 1'b0; t0 = cyc;
    wait_init(0, a);
    check("init0_lat", a - t0, 41);
    @(negedge clk);
    check("init0_width", init_start, 0);
    wait_init(1, b);
    check("init1_lat", b - t0, 45);
    wait_state(0, a);
    check("boot_idle_at", a - t0, 49);
    check("boot_dev_ok", dev_ok, 2'b11);
    check("boot_busy", busy, 0);
    check("boot_fail", init_fail, 0);

    // Reinit with device 1 silent: three attempts, 82-cycle period (1 start + 81 wait)
    init_lat[1] = 0;
    reinit = 1'b1; c0 = cyc;
    @(negedge clk);
    reinit = 1'b0;
    check("reinit_start0", init_start, 2'b01);
    check("reinit_clr_ok", dev_ok, 0);
    wait_init(1, a);
    check("retry_p1", a - c0, 5);
    wait_init(1, b);
    check("retry_gap1", b - a, 82);
    wait_init(1, a);
    check("retry_gap2", a - b, 82);
    wait_state(0, b);
    check("fail_idle_at", b - a, 82);
    check("fail_flag", init_fail, 1);
    check("fail_dev_ok", dev_ok, 2'b01);

    // Read to an uninitialised device is rejected
    rd_dev = 1'b1; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("rej_err", rd_err, 1);
    check("rej_state", state_out, 0);
    check("rej_nostart", rd_start, 0);
    @(negedge clk);
    check("rej_err_width", rd_err, 0);

    // Read device 0, done 2 cycles after the start pulse
    rd_dev = 1'b0; rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    check("rd0_start", rd_start, 2'b01);
    check("rd0_state", state_out, 4);
    @(negedge clk);
    check("rd0_single", rd_start, 0);
    check("rd0_wait", state_out, 5);
    @(negedge clk);
    check("rd0_no_early_ack", rd_ack, 0);
    @(negedge clk);
    check("rd0_ack", {rd_ack, rd_err}, 2'b10);
    check("rd0_idle", state_out, 0);
    @(negedge clk);
    check("rd0_ack_width", rd_ack, 0);

    // Held request: starts 4 cycles apart (start, wait, wait, idle)
    rd_req = 1'b1;
    wait_rd_start(0, a);
    wait_rd_start(0, b);
    rd_req = 1'b0;
    check("held_gap", b - a, 4);
    wait_state(0, a);

    // Read timeout: rd_err 21 cycles after RD_WAIT entry
    rd_lat[0] = 0;
    rd_req = 1'b1; c0 = cyc;
    @(negedge clk);
    rd_req = 1'b0;
    wait_rd_end(a);
    check("rd_to_at", a - c0, 23);
    check("rd_to_kind", {rd_ack, rd_err}, 2'b01);

    // Done on the timeout cycle: ack only
    rd_lat[0] = 21;
    rd_req = 1'b1; c0 = cyc;
    @(negedge clk);
    rd_req = 1'b0;
    wait_rd_end(a);
    check("rd_tie_at", a - c0, 23);
    check("rd_tie_kind", {rd_ack, rd_err}, 2'b10);

    // Lock lost during device 1 init wait, then relock
    init_lat[1] = 3;
    reinit = 1'b1; c0 = cyc;
    @(negedge clk);
    reinit = 1'b0;
    wait_init(1, a);
    check("drop_setup", a - c0, 5);
    @(negedge clk);
    check("drop_pre_state", state_out, 3);
    check("drop_pre_ok", dev_ok, 2'b01);
    pll_locked = 1'b0;
    @(negedge clk);
    check("drop_state", state_out, 1);
    check("drop_dev_ok", dev_ok, 0);
    check("drop_busy", busy, 1);
    check("drop_no_pulse", init_start, 0);
    repeat (5) @(negedge clk);
    check("unlocked_hold", state_out, 1);
    pll_locked = 1'b1; t0 = cyc;
    wait_init(0, a);
    check("relock_init0", a - t0, 41);
    wait_init(1, b);
    check("relock_init1", b - t0, 45);
    wait_state(0, a);
    check("relock_idle_at", a - t0, 49);
    check("relock_dev_ok", dev_ok, 2'b11);

    // Asynchronous reset in the middle of a read
    rd_lat[0] = 0;
    rd_req = 1'b1;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    check("rst_mid_pre", state_out, 5);
    reset = 1'b1;
    #1;
    check("rst_mid_state", state_out, 1);
    check("rst_mid_dev_ok", dev_ok, 0);
    check("rst_mid_busy", busy, 1);
    @(negedge clk);
    reset = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
